// File: rtl/step_move_ctrl.sv
// Move-command sequencer: accepts a direction/step-count command and paces one-cycle step strobes.
// Define STEP_MOVE_RAMP_EN to compile in the start-up acceleration ramp.
module step_move_ctrl #(
   parameter int unsigned PERIOD     = 262144,
   parameter int unsigned CNT_W      = 14,
   parameter int unsigned DIV_W      = 20,
   parameter int unsigned RAMP_START = 1048576,
   parameter int unsigned RAMP_DEC   = 32768
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic             abort,
   output logic             dir,
   output logic             en,
   output logic             step,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] steps_left
);

   typedef enum logic [1:0] {StIdle, StRun, StSettle, StDone} state_t;

   localparam logic [DIV_W-1:0] PerLim = DIV_W'(PERIOD - 1);
   // SETTLE starts with the prescaler already cleared on the last step edge
   localparam logic [DIV_W-1:0] SetLim = DIV_W'(PERIOD - 2);

   if (PERIOD < 2 || RAMP_START < PERIOD || 64'(RAMP_START) > (64'(1) << DIV_W) ||
       64'(RAMP_DEC) >= (64'(1) << DIV_W)) begin : g_cfg_err
      $error("step_move_ctrl: invalid PERIOD/RAMP_START/RAMP_DEC for DIV_W");
   end

   state_t           state;
   logic [DIV_W-1:0] pre;
   logic [DIV_W-1:0] cur_lim;  // current step period minus one

`ifdef STEP_MOVE_RAMP_EN
   localparam int unsigned      DW1      = DIV_W + 1;
   localparam logic [DIV_W-1:0] StartLim = DIV_W'(RAMP_START - 1);
   localparam logic [DW1-1:0]   DecW     = DW1'(RAMP_DEC);

   logic [DIV_W-1:0] next_lim;

   always_comb begin
      next_lim = PerLim;
      if ({1'b0, cur_lim} >= {1'b0, PerLim} + DecW) begin
         next_lim = cur_lim - DecW[DIV_W-1:0];
      end
   end
`else
   assign cur_lim = PerLim;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= StIdle;
         pre        <= '0;
         step       <= 1'b0;
         done       <= 1'b0;
         en         <= 1'b0;
         busy       <= 1'b0;
         cmd_ready  <= 1'b1;
         dir        <= 1'b0;
         steps_left <= '0;
`ifdef STEP_MOVE_RAMP_EN
         cur_lim    <= PerLim;
`endif
      end else begin
         step <= 1'b0;
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (cmd_valid) begin
                  dir        <= cmd_dir;
                  steps_left <= cmd_steps;
                  pre        <= '0;
                  cmd_ready  <= 1'b0;
`ifdef STEP_MOVE_RAMP_EN
                  cur_lim    <= StartLim;
`endif
                  if (cmd_steps == '0) begin
                     state <= StDone;
                     done  <= 1'b1;
                  end else begin
                     state <= StRun;
                     en    <= 1'b1;
                     busy  <= 1'b1;
                  end
               end
            end
            StRun: begin
               // The strobe already issued counts even when aborted in the same cycle
               if (step) begin
                  steps_left <= steps_left - CNT_W'(1);
               end
               if (abort) begin
                  state <= StDone;
                  done  <= 1'b1;
                  en    <= 1'b0;
                  busy  <= 1'b0;
               end else if (step) begin
                  pre <= '0;
`ifdef STEP_MOVE_RAMP_EN
                  cur_lim <= next_lim;
`endif
                  if (steps_left == CNT_W'(1)) begin
                     state <= StSettle;
                  end
               end else begin
                  pre  <= pre + DIV_W'(1);
                  step <= ((pre + DIV_W'(1)) == cur_lim);
               end
            end
            StSettle: begin
               if (abort || pre == SetLim) begin
                  state <= StDone;
                  done  <= 1'b1;
                  en    <= 1'b0;
                  busy  <= 1'b0;
               end else begin
                  pre <= pre + DIV_W'(1);
               end
            end
            StDone: begin
               state     <= StIdle;
               cmd_ready <= 1'b1;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_step_move_ctrl.sv
// Self-checking bench for step_move_ctrl: hand tables, corner sequences and a randomized schedule model.
`timescale 1ns/1ps
module tb_step_move_ctrl;

   localparam int PERIOD     = 4;
   localparam int CNT_W      = 14;
   localparam int DIV_W      = 20;
   localparam int RAMP_START = 10;
   localparam int RAMP_DEC   = 3;
`ifdef STEP_MOVE_RAMP_EN
   localparam int FIRST_PER = RAMP_START;
`else
   localparam int FIRST_PER = PERIOD;
`endif
   localparam int VW = CNT_W + 6;
   // {step, done, en, busy, cmd_ready, dir, steps_left}
   localparam logic [VW-1:0] RstVec = {6'b000010, {CNT_W{1'b0}}};

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_dir = 1'b0;
   logic [CNT_W-1:0] cmd_steps = '0;
   logic             abort = 1'b0;
   logic             cmd_ready, dir, en, step, busy, done;
   logic [CNT_W-1:0] steps_left;

   int tests = 0;
   int fails = 0;

   step_move_ctrl #(
      .PERIOD(PERIOD), .CNT_W(CNT_W), .DIV_W(DIV_W), .RAMP_START(RAMP_START), .RAMP_DEC(RAMP_DEC)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .cmd_steps(cmd_steps), .abort(abort), .dir(dir), .en(en), .step(step), .busy(busy),
      .done(done), .steps_left(steps_left)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   function automatic logic [VW-1:0] outs();
      return {step, done, en, busy, cmd_ready, dir, steps_left};
   endfunction

   task automatic check_vec(input string name, input int s, input logic [VW-1:0] a,
                            input logic [VW-1:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s s=%0d actual{stp,dn,en,bsy,rdy,dir,left}=%b_%0d required=%b_%0d",
                  name, s, a[VW-1:CNT_W], a[CNT_W-1:0], e[VW-1:CNT_W], e[CNT_W-1:0]);
      end
   endtask

   task automatic check_int(input string name, input int a, input int e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d", name, a, e);
      end
   endtask

   task automatic wait_ready(input string name);
      int k;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s_ready_timeout actual=%b required=1", name, cmd_ready);
      end
   endtask

   // Period of each step follows the ramp rule; s-index counts edges after acceptance.
   function automatic int model_done(input int n);
      int acc, p;
      acc = 0;
      p = FIRST_PER;
      for (int k = 0; k < n; k++) begin
         acc += p;
         p = (p - RAMP_DEC < PERIOD) ? PERIOD : p - RAMP_DEC;
      end
      return (n == 0) ? 0 : acc - 1 + PERIOD;
   endfunction

   task automatic run_move(input bit d, input int n, input int ab, input string name,
                           output int got_done, output int got_left);
      int sk[$];
      int acc, p, nd, dn, cnt;
      bit estep;
      logic [VW-1:0] e;
      acc = 0;
      p = FIRST_PER;
      for (int k = 0; k < n; k++) begin
         acc += p;
         sk.push_back(acc - 1);
         p = (p - RAMP_DEC < PERIOD) ? PERIOD : p - RAMP_DEC;
      end
      nd = (n == 0) ? 0 : sk[n-1] + PERIOD;
      dn = (ab >= 0 && ab < nd) ? ab + 1 : nd;
      wait_ready(name);
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_steps = CNT_W'(n);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_steps = CNT_W'($urandom_range(0, 99));
      cmd_dir   = ~d;
      got_done = -1;
      got_left = -1;
      for (int s = 0; s <= dn + 1; s++) begin
         if (s > 0) @(negedge clk);
         cnt = 0;
         estep = 1'b0;
         foreach (sk[i]) begin
            if (sk[i] < s && sk[i] < dn) cnt++;
            if (sk[i] == s && s < dn) estep = 1'b1;
         end
         e = {estep, s == dn, s < dn, s < dn, s > dn, d, CNT_W'(n - cnt)};
         check_vec(name, s, outs(), e);
         if (done === 1'b1 && got_done < 0) begin
            got_done = s;
            got_left = int'(steps_left);
         end
         abort = (s == ab);
      end
      abort = 1'b0;
   endtask

   typedef struct {
      bit d;
      int n;
      int ab;
      int done_s;
      int left;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int gd, gl, d1, nsteps, done1, done2, dirbad, rdy_gap, bsy2;

`ifdef STEP_MOVE_RAMP_EN
      tbl[0] = '{1'b1, 3, -1, 24, 0};
      tbl[1] = '{1'b0, 0, -1, 0, 0};
      tbl[2] = '{1'b1, 100, 16, 17, 98};
      tbl[3] = '{1'b0, 1, -1, 13, 0};
      tbl[4] = '{1'b1, 5, 18, 19, 3};
      tbl[5] = '{1'b1, 2, 9, 10, 1};
      tbl[6] = '{1'b0, 4, -1, 28, 0};
`else
      tbl[0] = '{1'b1, 3, -1, 15, 0};
      tbl[1] = '{1'b0, 0, -1, 0, 0};
      tbl[2] = '{1'b1, 100, 7, 8, 98};
      tbl[3] = '{1'b0, 1, -1, 7, 0};
      tbl[4] = '{1'b1, 5, 18, 19, 1};
      tbl[5] = '{1'b1, 2, 9, 10, 0};
      tbl[6] = '{1'b0, 4, -1, 19, 0};
`endif

      // Reset held for 5 clocks, then 20 idle clocks with no strobe
      repeat (5) @(negedge clk);
      check_vec("reset_hold", 0, outs(), RstVec);
      reset = 1'b1;
      for (int s = 0; s < 20; s++) begin
         @(negedge clk);
         check_vec("reset_idle", s, outs(), RstVec);
      end

      foreach (tbl[i]) begin
         run_move(tbl[i].d, tbl[i].n, tbl[i].ab, $sformatf("tbl%0d", i), gd, gl);
         check_int($sformatf("tbl%0d_done_s", i), gd, tbl[i].done_s);
         check_int($sformatf("tbl%0d_left", i), gl, tbl[i].left);
      end

      // Back-to-back: command held valid continuously
      wait_ready("b2b");
      d1 = model_done(2);
      cmd_valid = 1'b1;
      cmd_dir   = 1'b0;
      cmd_steps = CNT_W'(2);
      @(posedge clk);
      nsteps = 0; done1 = -1; done2 = -1; dirbad = 0; rdy_gap = 0; bsy2 = 0;
      for (int s = 0; s <= 2 * d1 + 3; s++) begin
         @(negedge clk);
         if (step === 1'b1) nsteps++;
         if (dir !== 1'b0) dirbad++;
         if (done === 1'b1) begin
            if (done1 < 0) done1 = s;
            else if (done2 < 0) done2 = s;
         end
         if (s == d1 + 1) rdy_gap = int'(cmd_ready);
         if (s == d1 + 2) bsy2 = int'(busy);
      end
      cmd_valid = 1'b0;
      check_int("b2b_done1", done1, d1);
      check_int("b2b_done2", done2, 2 * d1 + 2);
      check_int("b2b_steps", nsteps, 4);
      check_int("b2b_dir_errs", dirbad, 0);
      check_int("b2b_ready_gap", rdy_gap, 1);
      check_int("b2b_second_busy", bsy2, 1);

      // Asynchronous reset in the middle of a move
      wait_ready("arst");
      cmd_valid = 1'b1;
      cmd_dir   = 1'b1;
      cmd_steps = CNT_W'(50);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (9) @(negedge clk);
      check_int("arst_busy_before", int'(busy), 1);
      #2 reset = 1'b0;
      #1 check_vec("arst_immediate", 0, outs(), RstVec);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_vec("arst_after", 0, outs(), RstVec);

      // Randomized moves against the schedule model
      for (int r = 0; r < 30; r++) begin
         bit rd;
         int rn, rab;
         rd  = 1'($urandom_range(0, 1));
         rn  = int'($urandom_range(0, 12));
         rab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : -1;
         run_move(rd, rn, rab, $sformatf("rand%0d", r), gd, gl);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
